// File: rtl/lc3_control.sv
// lc3_control: multi-cycle fetch/decode/execute sequencer for the LC-3 datapath.
// Outputs are decoded from state and IR and are forced to zero while reset is asserted.
module lc3_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir,
   input  logic [2:0]  cc,
   input  logic        mem_ready,
   output logic        ld_ir,
   output logic        ld_reg,
   output logic        ld_pc,
   output logic        ld_cc,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        gate_alu,
   output logic        gate_pc,
   output logic        gate_marmux,
   output logic        gate_mdr,
   output logic [2:0]  dr,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [1:0]  aluk,
   output logic        a1m_sel,
   output logic [1:0]  a2m_sel,
   output logic [1:0]  pcmux_sel,
   output logic        marmux_sel,
   output logic        mem_en,
   output logic        mem_rw,
   output logic        instr_done,
   output logic        halted
);
   typedef enum logic [3:0] {
      FETCH1, FETCH2, FETCH3, DECODE, ALU, BR, JMP, JSR1,
      JSR2, LEA, ADDR, MEMRD, LDWB, STDATA, MEMWR, HALT
   } state_t;
   state_t state, state_next;
   logic ben;
   logic [3:0] op;
   assign op = ir[15:12];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH1;
         ben   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == DECODE) ben <= |(ir[11:9] & cc);
      end
   end
   always_comb begin
      state_next  = state;
      ld_ir       = 1'b0;
      ld_reg      = 1'b0;
      ld_pc       = 1'b0;
      ld_cc       = 1'b0;
      ld_mar      = 1'b0;
      ld_mdr      = 1'b0;
      gate_alu    = 1'b0;
      gate_pc     = 1'b0;
      gate_marmux = 1'b0;
      gate_mdr    = 1'b0;
      dr          = rst_n ? ir[11:9] : 3'd0;
      sr1         = rst_n ? ir[8:6] : 3'd0;
      sr2         = rst_n ? ir[2:0] : 3'd0;
      aluk        = 2'd0;
      a1m_sel     = 1'b0;
      a2m_sel     = 2'd0;
      pcmux_sel   = 2'd0;
      marmux_sel  = 1'b0;
      mem_en      = 1'b0;
      mem_rw      = 1'b0;
      instr_done  = 1'b0;
      halted      = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH1: begin
               gate_pc    = 1'b1;
               ld_mar     = 1'b1;
               pcmux_sel  = 2'd2;
               ld_pc      = 1'b1;
               state_next = FETCH2;
            end
            FETCH2: begin
               mem_en = 1'b1;
               ld_mdr = mem_ready;
               if (mem_ready) state_next = FETCH3;
            end
            FETCH3: begin
               gate_mdr   = 1'b1;
               ld_ir      = 1'b1;
               state_next = DECODE;
            end
            DECODE: begin
               case (op)
                  4'b0001, 4'b0101, 4'b1001:         state_next = ALU;
                  4'b0000:                           state_next = BR;
                  4'b1100:                           state_next = JMP;
                  4'b0100:                           state_next = JSR1;
                  4'b1110:                           state_next = LEA;
                  4'b0010, 4'b0011, 4'b0110, 4'b0111: state_next = ADDR;
                  default:                           state_next = HALT;
               endcase
            end
            ALU: begin
               aluk       = (op == 4'b0001) ? 2'd2 : (op == 4'b0101) ? 2'd0 : 2'd1;
               gate_alu   = 1'b1;
               ld_reg     = 1'b1;
               ld_cc      = 1'b1;
               instr_done = 1'b1;
               state_next = FETCH1;
            end
            BR: begin
               a1m_sel    = ben;
               a2m_sel    = {1'b0, ben};
               pcmux_sel  = {1'b0, ben};
               ld_pc      = ben;
               instr_done = 1'b1;
               state_next = FETCH1;
            end
            JMP: begin
               a2m_sel    = 2'd3;
               pcmux_sel  = 2'd1;
               ld_pc      = 1'b1;
               instr_done = 1'b1;
               state_next = FETCH1;
            end
            JSR1: begin
               gate_pc    = 1'b1;
               dr         = 3'd7;
               ld_reg     = 1'b1;
               state_next = JSR2;
            end
            JSR2: begin
               a1m_sel    = ir[11];
               a2m_sel    = ir[11] ? 2'd0 : 2'd3;
               pcmux_sel  = 2'd1;
               ld_pc      = 1'b1;
               instr_done = 1'b1;
               state_next = FETCH1;
            end
            LEA: begin
               a1m_sel     = 1'b1;
               a2m_sel     = 2'd1;
               marmux_sel  = 1'b1;
               gate_marmux = 1'b1;
               ld_reg      = 1'b1;
               instr_done  = 1'b1;
               state_next  = FETCH1;
            end
            // ir[14] separates base+offset6 forms, ir[12] separates stores
            ADDR: begin
               marmux_sel  = 1'b1;
               gate_marmux = 1'b1;
               ld_mar      = 1'b1;
               a1m_sel     = ~ir[14];
               a2m_sel     = ir[14] ? 2'd2 : 2'd1;
               state_next  = ir[12] ? STDATA : MEMRD;
            end
            MEMRD: begin
               mem_en = 1'b1;
               ld_mdr = mem_ready;
               if (mem_ready) state_next = LDWB;
            end
            LDWB: begin
               gate_mdr   = 1'b1;
               ld_reg     = 1'b1;
               ld_cc      = 1'b1;
               instr_done = 1'b1;
               state_next = FETCH1;
            end
            STDATA: begin
               sr1        = ir[11:9];
               aluk       = 2'd3;
               gate_alu   = 1'b1;
               ld_mdr     = 1'b1;
               state_next = MEMWR;
            end
            MEMWR: begin
               mem_rw     = 1'b1;
               instr_done = mem_ready;
               if (mem_ready) state_next = FETCH1;
            end
            HALT: halted = 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: directed vector table plus hand sequences for reset, stores, JSR and halt.
module tb_lc3_control;
   logic clk, rst_n, mem_ready;
   logic [15:0] ir;
   logic [2:0] cc;
   logic ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr;
   logic gate_alu, gate_pc, gate_marmux, gate_mdr;
   logic [2:0] dr, sr1, sr2;
   logic [1:0] aluk, a2m_sel, pcmux_sel;
   logic a1m_sel, marmux_sel, mem_en, mem_rw, instr_done, halted;
   typedef struct packed {
      logic ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr;
      logic gate_alu, gate_pc, gate_marmux, gate_mdr;
      logic [2:0] dr, sr1, sr2;
      logic [1:0] aluk;
      logic a1m;
      logic [1:0] a2m, pcm;
      logic marmux, mem_en, mem_rw, done, halted;
   } outs_t;
   typedef struct {
      logic [15:0] ir;
      logic [2:0]  cc;
      int          ws;
      int          waits;
      int          cycles;
      logic [6:0]  ctl;
      logic [2:0]  dr;
      logic [1:0]  aluk;
      logic        a1m;
      logic [1:0]  a2m;
      logic [1:0]  pcm;
      logic [31:0] mdr;
      logic [31:0] rw;
   } vec_t;
   outs_t o;
   int ncmp = 0, nfail = 0;
   assign o = {ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr, gate_alu, gate_pc, gate_marmux,
               gate_mdr, dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
               mem_en, mem_rw, instr_done, halted};
   lc3_control dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .cc(cc), .mem_ready(mem_ready),
      .ld_ir(ld_ir), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_cc(ld_cc), .ld_mar(ld_mar),
      .ld_mdr(ld_mdr), .gate_alu(gate_alu), .gate_pc(gate_pc), .gate_marmux(gate_marmux),
      .gate_mdr(gate_mdr), .dr(dr), .sr1(sr1), .sr2(sr2), .aluk(aluk), .a1m_sel(a1m_sel),
      .a2m_sel(a2m_sel), .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .mem_en(mem_en),
      .mem_rw(mem_rw), .instr_done(instr_done), .halted(halted)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Entered just after a rising edge with the FSM in FETCH1; returns likewise.
   task automatic run_instr(input vec_t v, input int pc_at, output int cyc, output outs_t fin,
                            output outs_t probe, output logic [31:0] mdr_m, output logic [31:0] rw_m);
      bit done = 1'b0;
      cyc = 0; fin = '0; probe = '0; mdr_m = '0; rw_m = '0;
      ir = v.ir;
      cc = v.cc;
      while (!done && cyc < 30) begin
         cyc++;
         mem_ready = (cyc >= v.ws && cyc < v.ws + v.waits) ? 1'b0 : 1'b1;
         @(negedge clk);
         chk("one_gate", 32'($countones({o.gate_alu, o.gate_pc, o.gate_marmux, o.gate_mdr}) <= 1), 32'd1);
         chk("mdr_rw_excl", {31'd0, o.ld_mdr & o.mem_rw}, 32'd0);
         if (o.ld_mdr) mdr_m[cyc] = 1'b1;
         if (o.mem_rw) rw_m[cyc] = 1'b1;
         if (cyc == pc_at) probe = o;
         if (o.done) begin
            done = 1'b1;
            fin = o;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk($sformatf("timeout ir=%h", v.ir), 32'd0, 32'd1);
   endtask
   vec_t tbl[$];
   vec_t hv;
   int cyc;
   outs_t fin, probe;
   logic [31:0] mdr_m, rw_m;
   initial begin
      tbl.push_back('{16'h12A3, 3'b000, 0, 0, 5,  7'b1011000, 3'd1, 2'd2, 1'b0, 2'd0, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'h5042, 3'b000, 0, 0, 5,  7'b1011000, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'h967F, 3'b000, 0, 0, 5,  7'b1011000, 3'd3, 2'd1, 1'b0, 2'd0, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'h0405, 3'b010, 0, 0, 5,  7'b0100000, 3'd2, 2'd0, 1'b1, 2'd1, 2'd1, 32'h4,   32'h0});
      tbl.push_back('{16'h0405, 3'b001, 0, 0, 5,  7'b0000000, 3'd2, 2'd0, 1'b0, 2'd0, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'h0E01, 3'b100, 0, 0, 5,  7'b0100000, 3'd7, 2'd0, 1'b1, 2'd1, 2'd1, 32'h4,   32'h0});
      tbl.push_back('{16'h0801, 3'b011, 0, 0, 5,  7'b0000000, 3'd4, 2'd0, 1'b0, 2'd0, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'hC0C0, 3'b000, 0, 0, 5,  7'b0100000, 3'd0, 2'd0, 1'b0, 2'd3, 2'd1, 32'h4,   32'h0});
      tbl.push_back('{16'hEC10, 3'b000, 0, 0, 5,  7'b1000010, 3'd6, 2'd0, 1'b1, 2'd1, 2'd0, 32'h4,   32'h0});
      tbl.push_back('{16'h4803, 3'b000, 0, 0, 6,  7'b0100000, 3'd4, 2'd0, 1'b1, 2'd0, 2'd1, 32'h4,   32'h0});
      tbl.push_back('{16'h4080, 3'b000, 0, 0, 6,  7'b0100000, 3'd0, 2'd0, 1'b0, 2'd3, 2'd1, 32'h4,   32'h0});
      tbl.push_back('{16'h2405, 3'b000, 0, 0, 7,  7'b1010001, 3'd2, 2'd0, 1'b0, 2'd0, 2'd0, 32'h44,  32'h0});
      tbl.push_back('{16'h673E, 3'b000, 6, 3, 10, 7'b1010001, 3'd3, 2'd0, 1'b0, 2'd0, 2'd0, 32'h204, 32'h0});
      tbl.push_back('{16'h3A10, 3'b000, 0, 0, 7,  7'b0000000, 3'd5, 2'd0, 1'b0, 2'd0, 2'd0, 32'h44,  32'h80});
      tbl.push_back('{16'h7B41, 3'b000, 7, 2, 9,  7'b0000000, 3'd5, 2'd0, 1'b0, 2'd0, 2'd0, 32'h44,  32'h380});
      tbl.push_back('{16'h12A3, 3'b000, 2, 2, 7,  7'b1011000, 3'd1, 2'd2, 1'b0, 2'd0, 2'd0, 32'h10,  32'h0});
      rst_n = 1'b0; ir = 16'h0; cc = 3'b000; mem_ready = 1'b1;
      #12;
      chk("reset_outs", {1'b0, o}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // Reset abandons an LDR stalled in its memory read
      ir = 16'h673E;
      for (int c = 1; c <= 7; c++) begin
         mem_ready = (c < 6);
         @(posedge clk);
         #1;
      end
      chk("ldr_stalled_mem_en", {31'd0, o.mem_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("midldr_reset_outs", {1'b0, o}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("post_reset_fetch1", {26'd0, o.gate_pc, o.ld_mar, o.ld_pc, o.pcm, o.ld_mdr},
          {26'd0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0});
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      foreach (tbl[i]) begin
         run_instr(tbl[i], 0, cyc, fin, probe, mdr_m, rw_m);
         chk($sformatf("cycles[%0d]", i), cyc, tbl[i].cycles);
         chk($sformatf("ctl[%0d]", i), {25'd0, fin.ld_reg, fin.ld_pc, fin.ld_cc, fin.gate_alu,
             fin.gate_pc, fin.gate_marmux, fin.gate_mdr}, {25'd0, tbl[i].ctl});
         chk($sformatf("sel[%0d]", i), {22'd0, fin.dr, fin.aluk, fin.a1m, fin.a2m, fin.pcm},
             {22'd0, tbl[i].dr, tbl[i].aluk, tbl[i].a1m, tbl[i].a2m, tbl[i].pcm});
         chk($sformatf("ld_mdr_cycles[%0d]", i), mdr_m, tbl[i].mdr);
         chk($sformatf("mem_rw_cycles[%0d]", i), rw_m, tbl[i].rw);
      end
      hv = tbl[13];
      run_instr(hv, 6, cyc, fin, probe, mdr_m, rw_m);
      chk("st_stdata", {23'd0, probe.sr1, probe.aluk, probe.ld_mdr, probe.mem_en, probe.gate_alu},
          {23'd0, 3'd5, 2'd3, 1'b1, 1'b0, 1'b1});
      hv = tbl[9];
      run_instr(hv, 5, cyc, fin, probe, mdr_m, rw_m);
      chk("jsr1", {27'd0, probe.dr, probe.gate_pc, probe.ld_reg}, {27'd0, 3'd7, 1'b1, 1'b1});
      chk("jsr2", {29'd0, fin.a1m, fin.a2m}, {29'd0, 1'b1, 2'd0});
      ir = 16'hF025;
      mem_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c < 5) chk($sformatf("trap_halted_c%0d", c), {31'd0, o.halted}, 32'd0);
         else begin
            chk($sformatf("trap_halted_c%0d", c), {31'd0, o.halted}, 32'd1);
            chk($sformatf("trap_no_ld_c%0d", c),
                {26'd0, o.ld_ir, o.ld_reg, o.ld_pc, o.ld_cc, o.ld_mar, o.ld_mdr}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #2 chk("halt_reset_outs", {1'b0, o}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("halt_exit_fetch1", {30'd0, o.gate_pc, o.halted}, {30'd0, 1'b1, 1'b0});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
